// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-master memory-access arbiter.
package mem_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_BUSY0 = 2'd1;
  localparam logic [1:0] ARB_BUSY1 = 2'd2;

  localparam logic ARB_M_CPU = 1'b0;
  localparam logic ARB_M_AUX = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = ARB_IDLE,
    StBusy0 = ARB_BUSY0,
    StBusy1 = ARB_BUSY1
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// Per-transaction watchdog: flags the cycle a granted transaction has waited too long.
module mem_arbiter_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  input  logic hold_off,
  output logic expire
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] cnt_q;

  // Cycle counter: restarts on each grant, counts every busy cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  if (TIMEOUT_CYCLES == 0) begin : g_disabled
    assign expire = 1'b0;
  end else begin : g_enabled
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);
    // A slave completion in the final cycle beats the watchdog.
    assign expire = enable & (cnt_q == LastCnt) & ~hold_off;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master, one-slave round-robin arbiter for the ma_* bus with a hung-slave watchdog.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_data_out,
  input  logic [3:0]        m0_data_mask,
  input  logic              m0_rd_req,
  input  logic              m0_wr_req,
  output logic [31:0]       m0_data_in,
  output logic              m0_done,
  output logic              m0_timeout,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_data_out,
  input  logic [3:0]        m1_data_mask,
  input  logic              m1_rd_req,
  input  logic              m1_wr_req,
  output logic [31:0]       m1_data_in,
  output logic              m1_done,
  output logic              m1_timeout,
  output logic [ADDR_W-1:0] s_addr,
  output logic [31:0]       s_data_out,
  output logic [3:0]        s_data_mask,
  output logic              s_rd_req,
  output logic              s_wr_req,
  input  logic [31:0]       s_data_in,
  input  logic              s_done,
  input  logic              s_timeout
);

  arb_state_e state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       req0, req1, busy, wd_clear, wd_expire, slave_end;

  assign req0      = m0_rd_req | m0_wr_req;
  assign req1      = m1_rd_req | m1_wr_req;
  assign busy      = (state_q != StIdle);
  assign wd_clear  = (state_q == StIdle) && (state_d != StIdle);
  assign slave_end = s_done | s_timeout;

  assign m0_data_in = s_data_in;
  assign m1_data_in = s_data_in;

  mem_arbiter_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .enable  (busy),
    .hold_off(slave_end),
    .expire  (wd_expire)
  );

  // State and round-robin pointer; last_grant resets to AUX so the CPU wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= ARB_M_AUX;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state: grant in IDLE, return to IDLE on completion, failure, expiry or dropped request.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StIdle: begin
        if (req0 && (!req1 || (last_grant_q == ARB_M_AUX))) begin
          state_d      = StBusy0;
          last_grant_d = ARB_M_CPU;
        end else if (req1) begin
          state_d      = StBusy1;
          last_grant_d = ARB_M_AUX;
        end
      end
      StBusy0: if (slave_end || wd_expire || !req0) state_d = StIdle;
      StBusy1: if (slave_end || wd_expire || !req1) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output mux: only the owning master sees the slave; expiry drops the slave request at once.
  always_comb begin
    s_addr      = '0;
    s_data_out  = '0;
    s_data_mask = '0;
    s_rd_req    = 1'b0;
    s_wr_req    = 1'b0;
    m0_done     = 1'b0;
    m0_timeout  = 1'b0;
    m1_done     = 1'b0;
    m1_timeout  = 1'b0;
    unique case (state_q)
      StBusy0: begin
        s_addr      = m0_addr;
        s_data_out  = m0_data_out;
        s_data_mask = m0_data_mask;
        s_rd_req    = m0_rd_req & ~wd_expire;
        s_wr_req    = m0_wr_req & ~wd_expire;
        m0_done     = s_done;
        m0_timeout  = s_timeout | wd_expire;
      end
      StBusy1: begin
        s_addr      = m1_addr;
        s_data_out  = m1_data_out;
        s_data_mask = m1_data_mask;
        s_rd_req    = m1_rd_req & ~wd_expire;
        s_wr_req    = m1_wr_req & ~wd_expire;
        m1_done     = s_done;
        m1_timeout  = s_timeout | wd_expire;
      end
      default: ;
    endcase
  end

endmodule
